// File: rtl/foo_pair_pipe.sv
// Lane-parallel AND/OR/XOR/ADD unit feeding a DEPTH-entry result buffer.
// Results leave in acceptance order; ovf_sticky latches any ADD carry.
module foo_pair_pipe #(
   parameter int WIDTH = 8,
   parameter int LANES = 2,
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [1:0]                mode,
   input  logic [LANES*WIDTH-1:0]    a,
   input  logic [LANES*WIDTH-1:0]    b,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*WIDTH-1:0]    d,
   output logic [LANES-1:0]          carry,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                      ovf_sticky,
   input  logic                      clr_ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   localparam logic [1:0] MODE_AND = 2'b00;
   localparam logic [1:0] MODE_OR  = 2'b01;
   localparam logic [1:0] MODE_XOR = 2'b10;
   localparam logic [1:0] MODE_ADD = 2'b11;

   // Handshake: a beat transfers on any clk edge where valid && ready on
   // that side; ready never depends combinationally on valid.
   logic                   accept;
   logic                   pop;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count_q;
   logic                   ovf_q;
   logic [LANES*WIDTH-1:0] res_d;
   logic [LANES-1:0]       res_c;
   logic [WIDTH:0]         sum;

   logic [LANES*WIDTH-1:0] d_mem [DEPTH];
   logic [LANES-1:0]       c_mem [DEPTH];

   assign in_ready  = (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;
   assign ovf_sticky = ovf_q;
   assign d         = out_valid ? d_mem[rd_ptr] : '0;
   assign carry     = out_valid ? c_mem[rd_ptr] : '0;

   always_comb begin
      res_d = '0;
      res_c = '0;
      sum   = '0;
      for (int i = 0; i < LANES; i++) begin
         sum = {1'b0, a[i*WIDTH +: WIDTH]} + {1'b0, b[i*WIDTH +: WIDTH]};
         case (mode)
            MODE_AND: res_d[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] & b[i*WIDTH +: WIDTH];
            MODE_OR:  res_d[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] | b[i*WIDTH +: WIDTH];
            MODE_XOR: res_d[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] ^ b[i*WIDTH +: WIDTH];
            default: begin
               res_d[i*WIDTH +: WIDTH] = sum[WIDTH-1:0];
               res_c[i]                = sum[WIDTH];
            end
         endcase
      end
   end

   // Storage has no reset; count alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (accept) begin
         d_mem[wr_ptr] <= res_d;
         c_mem[wr_ptr] <= res_c;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept) wr_ptr <= wr_ptr + PW'(1);
         if (pop)    rd_ptr <= rd_ptr + PW'(1);
         if (accept && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !accept) count_q <= count_q - CW'(1);
         // Set beats clear when both land in the same cycle.
         if (accept && (mode == MODE_ADD) && (|res_c)) ovf_q <= 1'b1;
         else if (clr_ovf)                             ovf_q <= 1'b0;
      end
   end

endmodule

// File: doc/foo_pair_pipe.md
FOO_PAIR_PIPE -- requirements
Module: foo_pair_pipe

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter WIDTH, default 8: lane data width in bits, 1..32.
REQ-003 Parameter LANES, default 2: number of parallel a/b/d lanes, 1..8.
REQ-004 Parameter DEPTH, default 4: result buffer entries, a power of 2 and at least 2.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  an input beat is offered.
REQ-008 in_ready  out  1  the block can accept a beat.
REQ-009 mode  in  2  operation for the offered beat: 00 AND, 01 OR, 10 XOR, 11 ADD.
REQ-010 a  in  LANES*WIDTH  operand A; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-011 b  in  LANES*WIDTH  operand B; same lane packing as a.
REQ-012 out_valid  out  1  the buffer head holds a result.
REQ-013 out_ready  in  1  the consumer takes the head result.
REQ-014 d  out  LANES*WIDTH  result at the buffer head.
REQ-015 carry  out  LANES  per-lane carry-out of the head result.
REQ-016 count  out  $clog2(DEPTH+1)  number of buffered results.
REQ-017 ovf_sticky  out  1  latched indication that an ADD carry occurred.
REQ-018 clr_ovf  in  1  clears ovf_sticky.

Function
REQ-019 An accept SHALL occur when in_valid && in_ready at a clk edge; a pop SHALL occur when out_valid && out_ready.
REQ-020 in_ready SHALL equal (count < DEPTH), derived only from registered state; there is no pass-through when the buffer is full.
REQ-021 On accept, each lane result SHALL be computed from a, b and mode sampled in that cycle.
- AND, OR and XOR are bitwise, with carry = 0.
- ADD is modulo 2^WIDTH, with carry = bit WIDTH of the sum.
REQ-022 The result and carries of an accepted beat SHALL be written into the buffer at the write pointer.
REQ-023 The write and read pointers SHALL wrap modulo DEPTH.
REQ-024 Latency SHALL be one cycle: for a beat accepted at edge k into an empty buffer, out_valid is 1 and d/carry are valid after edge k.
REQ-025 out_valid SHALL equal (count != 0).
REQ-026 d and carry SHALL present the head entry when out_valid = 1, and SHALL be 0 when out_valid = 0.
REQ-027 Results SHALL leave in acceptance order; no beat is dropped or duplicated.
REQ-028 count SHALL update as follows:
- +1 on accept only.
- -1 on pop only.
- unchanged on simultaneous accept and pop.
REQ-029 out_ready while out_valid = 0 SHALL have no effect.
REQ-030 ovf_sticky SHALL set on any accepted ADD beat with any lane carry = 1; it SHALL clear on clr_ovf; set SHALL win when both occur in the same cycle.
REQ-031 mode, a and b SHALL be ignored in cycles without an accept.

Reset
REQ-032 With rst = 1 at an edge, the following SHALL be 0 after that edge, taking priority over any accept or pop in the same cycle:
- count, both pointers, out_valid, d, carry, ovf_sticky.
- in_ready SHALL be 1 after that edge.
REQ-033 A reset mid-operation SHALL discard all buffered results; buffer storage need not be cleared.

Verification (WIDTH=8, LANES=2, DEPTH=4)
REQ-034 Reset: hold rst for 2 cycles -> out_valid=0, d=0x0000, carry=2'b00, count=0, ovf_sticky=0, in_ready=1.
REQ-035 ADD carry: mode=11, a=0xF001, b=0x2002, one beat, out_ready=0 -> next cycle out_valid=1, d=0x1003, carry=2'b10, ovf_sticky=1, count=1.
REQ-036 Full/backpressure: out_ready=0, push XOR beats a=0x00n0, b=0x000F for n=1..5 -> after 4 accepts count=4 and in_ready=0, and the 5th beat is held. Then out_ready=1 -> d sequence 0x001F, 0x002F, 0x003F, 0x004F, then 0x005F, with the 5th accepted once in_ready=1.
REQ-037 Simultaneous push/pop: with count=2, in_valid=1 and out_ready=1 for 3 cycles -> count stays 2 and output order is preserved.
REQ-038 Sticky priority: with ovf_sticky=1, assert clr_ovf together with an accepted ADD a=0x00FF, b=0x0001 -> ovf_sticky remains 1; a following clr_ovf with no carry -> 0.
REQ-039 Mid-operation reset: with count=3, pulse rst -> next cycle count=0, out_valid=0, d=0; a new AND beat a=0x0F0F, b=0x00FF then yields d=0x000F.
